// File: rtl/cas_player_pkg.sv
// Shared constants for the cassette replay block: FSM state encodings and
// the download index values that the OSD loader and the player agree on.
package cas_player_pkg;

  // Download index values assigned by the OSD file menu
  localparam logic [7:0] DN_IDX_ROM      = 8'd0;
  localparam logic [7:0] DN_IDX_CAS      = 8'd1;
  localparam logic [7:0] CAS_IDX_DEFAULT = DN_IDX_CAS;

  // Playback FSM state encodings
  typedef logic [2:0] cas_state_t;
  localparam cas_state_t ST_IDLE  = 3'd0;
  localparam cas_state_t ST_FETCH = 3'd1;
  localparam cas_state_t ST_WAIT  = 3'd2;
  localparam cas_state_t ST_LOAD  = 3'd3;
  localparam cas_state_t ST_CELL  = 3'd4;
  localparam cas_state_t ST_NEXT  = 3'd5;
  localparam cas_state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/cas_bitcell.sv
// One 500-baud bit cell: free-running cell counter plus the clock/data
// pulse shaper. The counter wraps on its own so consecutive bits of a byte
// need no restart; start_i re-aligns it at the beginning of every byte.
module cas_bitcell #(
  parameter int CELL_CLKS  = 84000,
  parameter int PULSE_CLKS = 4200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic bit_i,
  input  logic enable_i,
  output logic pulse_o,
  output logic cell_done_o
);

  localparam int CW = $clog2(CELL_CLKS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CELL_CLKS - 1);
  localparam logic [CW-1:0] CLK_END    = CW'(PULSE_CLKS);
  localparam logic [CW-1:0] DATA_START = CW'(CELL_CLKS / 2);
  localparam logic [CW-1:0] DATA_END   = CW'(CELL_CLKS / 2 + PULSE_CLKS);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next cell count: restart on byte start, otherwise advance and wrap when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Cell counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (cnt_q < CLK_END) |
                   (bit_i & (cnt_q >= DATA_START) & (cnt_q < DATA_END));
  assign cell_done_o = enable_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/cas_player.sv
// TRS-80 Level II .CAS replay: captures the image length as the OSD writes
// the download buffer, then streams the bytes back MSB first as clock/data
// pulses while the CPU holds the cassette motor on.
module cas_player
  import cas_player_pkg::*;
#(
  parameter int         CELL_CLKS  = 84000,
  parameter int         PULSE_CLKS = 4200,
  parameter logic [7:0] CAS_IDX    = CAS_IDX_DEFAULT
) (
  input  logic        clk42m,
  input  logic        reset_n,
  input  logic        dn_go,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_idx,
  input  logic        motor,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        cas_out,
  output logic        busy,
  output logic        done
);

  cas_state_t  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [16:0] len_q, len_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic        wrote_q, wrote_d;
  logic        loaded_q, loaded_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        cas_out_q, cas_out_d;
  logic        dn_go_q;

  logic dn_rise, dn_fall, cas_wr;
  logic cell_start, cell_enable, cell_pulse, cell_done;

  assign dn_rise     = dn_go & ~dn_go_q;
  assign dn_fall     = ~dn_go & dn_go_q;
  assign cas_wr      = dn_go & dn_wr & (dn_idx == CAS_IDX);
  assign cell_enable = motor & ~dn_rise & (state_q == ST_CELL);

  cas_bitcell #(
    .CELL_CLKS  (CELL_CLKS),
    .PULSE_CLKS (PULSE_CLKS)
  ) u_bitcell (
    .clk_i       (clk42m),
    .rst_ni      (reset_n),
    .start_i     (cell_start),
    .bit_i       (shreg_q[7]),
    .enable_i    (cell_enable),
    .pulse_o     (cell_pulse),
    .cell_done_o (cell_done)
  );

  // Playback FSM, length capture and download rewind; motor low freezes playback
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    last_addr_d = last_addr_q;
    wrote_d     = wrote_q;
    loaded_d    = loaded_q;
    done_d      = done_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    cas_out_d   = 1'b0;
    cell_start  = 1'b0;

    if (motor) begin
      case (state_q)
        ST_IDLE: begin
          if (loaded_q && !done_q) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          mem_rd_d   = 1'b1;
          mem_addr_d = ptr_q;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          shreg_d    = mem_data;
          bitcnt_d   = 3'd7;
          cell_start = 1'b1;
          state_d    = ST_CELL;
        end
        ST_CELL: begin
          cas_out_d = cell_pulse;
          if (cell_done) begin
            if (bitcnt_q != 3'd0) begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q - 3'd1;
            end else begin
              state_d = ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          ptr_d = ptr_q + 16'd1;
          if (({1'b0, ptr_q} + 17'd1) == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (dn_rise) begin
      state_d    = ST_IDLE;
      loaded_d   = 1'b0;
      done_d     = 1'b0;
      wrote_d    = 1'b0;
      mem_rd_d   = 1'b0;
      cas_out_d  = 1'b0;
      cell_start = 1'b0;
    end

    if (cas_wr) begin
      last_addr_d = dn_addr;
      wrote_d     = 1'b1;
    end

    if (dn_fall && wrote_q) begin
      len_d    = {1'b0, last_addr_q} + 17'd1;
      ptr_d    = 16'd0;
      loaded_d = 1'b1;
      done_d   = 1'b0;
      state_d  = ST_IDLE;
    end

    busy_d = loaded_d & ~done_d;
  end

  // State and output registers; reset discards the captured image length
  always_ff @(posedge clk42m) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      last_addr_q <= '0;
      wrote_q     <= 1'b0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      cas_out_q   <= 1'b0;
      dn_go_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      last_addr_q <= last_addr_d;
      wrote_q     <= wrote_d;
      loaded_q    <= loaded_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      cas_out_q   <= cas_out_d;
      dn_go_q     <= dn_go;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign cas_out  = cas_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player with shortened cells (100 clocks, 10-clock pulses).
// Buffer reads are scoreboarded against expected addresses; cas_out, busy
// and done are compared every cycle against a timing model of the stream.
module tb_cas_player;

  localparam int CELL   = 100;
  localparam int PULSE  = 10;
  localparam int PERIOD = 8 * CELL + 4;

  logic        clk42m = 1'b0;
  logic        reset_n = 1'b0;
  logic        dn_go = 1'b0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_idx = '0;
  logic        motor = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        mem_rd, cas_out, busy, done;
  logic [15:0] mem_addr;

  logic [7:0]  mem [0:255];
  logic [7:0]  img [0:3];
  logic [15:0] expAddrQ [$];
  int          checksTotal = 0;
  int          checksPassed = 0;

  typedef struct {
    logic        go;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  idx;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t vecs [8];

  cas_player #(
    .CELL_CLKS  (CELL),
    .PULSE_CLKS (PULSE),
    .CAS_IDX    (8'd1)
  ) dut (
    .clk42m   (clk42m),
    .reset_n  (reset_n),
    .dn_go    (dn_go),
    .dn_wr    (dn_wr),
    .dn_addr  (dn_addr),
    .dn_idx   (dn_idx),
    .motor    (motor),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cas_out  (cas_out),
    .busy     (busy),
    .done     (done)
  );

  // 42 MHz system clock stand-in
  always #5 clk42m = ~clk42m;

  // Download buffer RAM model: data valid the cycle after the read strobe
  always @(posedge clk42m) begin
    if (mem_rd) mem_data <= mem[mem_addr[7:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Scoreboard: every buffer read must match the next expected address
  always @(negedge clk42m) begin
    if (mem_rd === 1'b1) begin
      if (expAddrQ.size() == 0) checkOutput("unexpected mem_rd", mem_rd, 0);
      else checkOutput("mem_addr", mem_addr, expAddrQ.pop_front());
    end
  end

  // Expected cas_out after the e-th motor-high edge of a playback
  function automatic logic expCas(input int e, input int nBytes);
    int   u, b, r, c, j;
    logic bitv;
    if (e < 5) return 1'b0;
    u = e - 5;
    b = u / PERIOD;
    if (b >= nBytes) return 1'b0;
    r = u % PERIOD;
    if (r >= 8 * CELL) return 1'b0;
    c = r / CELL;
    j = r % CELL;
    bitv = img[b][7 - c];
    return (j < PULSE) || (bitv && (j >= CELL / 2) && (j < CELL / 2 + PULSE));
  endfunction

  task automatic applyStimulus(input vec_t v);
    dn_go   = v.go;
    dn_wr   = v.wr;
    dn_addr = v.addr;
    dn_idx  = v.idx;
  endtask

  task automatic downloadImage(input int n);
    @(negedge clk42m);
    dn_go = 1'b1; dn_idx = 8'd1; dn_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk42m);
      dn_wr = 1'b1; dn_addr = 16'(i); mem[i] = img[i];
    end
    @(negedge clk42m);
    dn_wr = 1'b0;
    @(negedge clk42m);
    dn_go = 1'b0;
    @(negedge clk42m);
    checkOutput("busy after download", busy, 1);
    checkOutput("done after download", done, 0);
  endtask

  task automatic playImage(input int nBytes, input int pauseAt, input int pauseLen);
    int   e = 0;
    int   pauseLeft = 0;
    bit   pauseUsed = 0;
    logic m;
    int   doneEdge = nBytes * PERIOD + 1;
    int   budget = doneEdge + pauseLen + 10;
    for (int i = 0; i < nBytes; i++) expAddrQ.push_back(16'(i));
    for (int k = 0; k < budget; k++) begin
      if (!pauseUsed && pauseLen > 0 && e == pauseAt) begin
        pauseLeft = pauseLen;
        pauseUsed = 1;
      end
      m = (pauseLeft == 0);
      if (pauseLeft > 0) pauseLeft--;
      motor = m;
      @(posedge clk42m);
      if (m) e++;
      @(negedge clk42m);
      checkOutput("cas_out", cas_out, m ? expCas(e, nBytes) : 1'b0);
      checkOutput("done", done, e >= doneEdge);
      checkOutput("busy", busy, e < doneEdge);
    end
    motor = 1'b0;
    checkOutput("reads left", expAddrQ.size(), 0);
  endtask

  initial begin
    img = '{8'hA5, 8'h00, 8'hFF, 8'h00};
    vecs[0] = '{1'b1, 1'b0, 16'd0, 8'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'd0, 8'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'd1, 8'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'd2, 8'd1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'd7, 8'd2, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'd0, 8'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'd0, 8'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'd0, 8'd0, 1'b1, 1'b0};

    repeat (3) @(negedge clk42m);
    checkOutput("reset cas_out", cas_out, 0);
    checkOutput("reset mem_rd", mem_rd, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) mem[i] = img[i];
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk42m);
      checkOutput("vec busy", busy, vecs[i].expBusy);
      checkOutput("vec done", done, vecs[i].expDone);
      checkOutput("vec cas_out", cas_out, 0);
    end

    $display("[TB] three-byte image A5 00 FF");
    playImage(3, -1, 0);
    motor = 1'b1;
    repeat (20) begin
      @(negedge clk42m);
      checkOutput("cas_out after done", cas_out, 0);
      checkOutput("done held", done, 1);
    end
    motor = 1'b0;

    $display("[TB] single byte A5");
    downloadImage(1);
    playImage(1, -1, 0);

    $display("[TB] single byte A5 with motor pause");
    downloadImage(1);
    playImage(1, 334, 200);

    $display("[TB] rewind mid-playback");
    downloadImage(1);
    expAddrQ.push_back(16'd0);
    motor = 1'b1;
    repeat (150) @(negedge clk42m);
    checkOutput("busy mid-play", busy, 1);
    dn_go = 1'b1; dn_idx = 8'd0;
    @(negedge clk42m);
    dn_go = 1'b0;
    checkOutput("rewind busy", busy, 0);
    checkOutput("rewind done", done, 0);
    checkOutput("rewind cas_out", cas_out, 0);
    repeat (100) begin
      @(negedge clk42m);
      checkOutput("cas_out after rewind", cas_out, 0);
      checkOutput("busy after rewind", busy, 0);
    end
    checkOutput("reads left after rewind", expAddrQ.size(), 0);
    motor = 1'b0;

    $display("[TB] reset mid-cell");
    downloadImage(1);
    expAddrQ.push_back(16'd0);
    motor = 1'b1;
    repeat (150) @(negedge clk42m);
    reset_n = 1'b0;
    @(negedge clk42m);
    reset_n = 1'b1;
    checkOutput("mid reset cas_out", cas_out, 0);
    checkOutput("mid reset mem_rd", mem_rd, 0);
    checkOutput("mid reset mem_addr", mem_addr, 0);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset done", done, 0);
    repeat (50) begin
      @(negedge clk42m);
      checkOutput("cas_out after reset", cas_out, 0);
      checkOutput("busy after reset", busy, 0);
    end
    checkOutput("reads left after reset", expAddrQ.size(), 0);
    motor = 1'b0;

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
